mem_dump_ctrl: RTL and testbench

- Consumes the CPU's is_display (halt) indication and streams data memory out, word by word, to the testbench display/logging sink.
- Sits directly downstream of the CPU core. Owns a dedicated synchronous read port on data memory.
- Presents each word with its index over a valid/ready handshake.
- Raises a sticky done flag so the bench can stop simulation.

---
 rtl/mem_dump_pkg.sv | 18 +
 rtl/rise_detect.sv | 24 ++
 rtl/mem_dump_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_dump_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types and default sizes for the memory dump controller.
// The optional zero-skipping behaviour is enabled by defining MEM_DUMP_SKIP_ZERO_EN.
package mem_dump_pkg;

   // Controller states; the encoding is kept at 3 bits so the state register width is fixed
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      DONE = 3'd4
   } dump_state_t;

   // Default geometry of the data memory being dumped
   localparam int DUMP_ADDR_W = 9;
   localparam int DUMP_DATA_W = 32;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector. The previous input level is held in a flop
// cleared by reset, so an input that is already high when reset releases is
// reported as a rising edge.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic din_q;

   // Remember the level seen on the previous clock edge
   always_ff @(posedge clk) begin
      if (rst) begin
         din_q <= 1'b0;
      end else begin
         din_q <= din;
      end
   end

   assign rise = din & ~din_q;

endmodule

// File: rtl/mem_dump_ctrl.sv
// Memory dump controller: on a rising edge of the CPU halt/display request it
// reads data memory word by word through its own synchronous read port and
// presents each word with its index over a valid/ready handshake, then raises a
// sticky done flag. Defining MEM_DUMP_SKIP_ZERO_EN suppresses beats for words
// that read as zero.
module mem_dump_ctrl
   import mem_dump_pkg::*;
#(
   parameter int ADDR_W = DUMP_ADDR_W,
   parameter int DATA_W = DUMP_DATA_W,
   parameter int DEPTH  = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              is_display,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [DATA_W-1:0] dump_data,
   output logic [ADDR_W-1:0] dump_index,
   output logic              busy,
   output logic              dump_done
);

   // Index of the final word; comparing against it (rather than DEPTH) lets
   // DEPTH equal 2**ADDR_W without the counter ever needing to wrap.
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   dump_state_t       state;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] cnt_nxt;
   logic              trig;

   assign cnt_nxt = cnt + 1'b1;

   rise_detect u_rise (
      .clk  (clk),
      .rst  (rst),
      .din  (is_display),
      .rise (trig)
   );

   // Dump sequencer: issue a read, capture the returned word, hold it until the
   // sink accepts it, then advance or finish. All outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
         dump_valid  <= 1'b0;
         dump_data   <= '0;
         dump_index  <= '0;
         busy        <= 1'b0;
         dump_done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (trig) begin
                  state       <= READ;
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= cnt;
                  busy        <= 1'b1;
               end
            end

            READ: begin
               mem_rd_en <= 1'b0;
               state     <= WAIT;
            end

            WAIT: begin
`ifdef MEM_DUMP_SKIP_ZERO_EN
               if (mem_rd_data == '0) begin
                  if (cnt == LAST_IDX) begin
                     state     <= DONE;
                     busy      <= 1'b0;
                     dump_done <= 1'b1;
                  end else begin
                     cnt         <= cnt_nxt;
                     mem_rd_addr <= cnt_nxt;
                     mem_rd_en   <= 1'b1;
                     state       <= READ;
                  end
               end else begin
                  dump_data  <= mem_rd_data;
                  dump_index <= cnt;
                  dump_valid <= 1'b1;
                  state      <= HOLD;
               end
`else
               dump_data  <= mem_rd_data;
               dump_index <= cnt;
               dump_valid <= 1'b1;
               state      <= HOLD;
`endif
            end

            HOLD: begin
               if (dump_ready) begin
                  dump_valid <= 1'b0;
                  if (cnt == LAST_IDX) begin
                     state     <= DONE;
                     busy      <= 1'b0;
                     dump_done <= 1'b1;
                  end else begin
                     cnt         <= cnt_nxt;
                     mem_rd_addr <= cnt_nxt;
                     mem_rd_en   <= 1'b1;
                     state       <= READ;
                  end
               end
            end

            DONE: begin
               state <= DONE;
            end

            default: begin
               state      <= IDLE;
               mem_rd_en  <= 1'b0;
               dump_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Self-checking bench for mem_dump_ctrl with a 4-word memory (ADDR_W=2).
// A cycle table covers reset, the basic stream, the boundary index and the
// level trigger; hand sequences cover backpressure, reset mid-dump and zero words.
module tb_mem_dump_ctrl;

   localparam int AW = 2;
   localparam int DW = 32;
   localparam int DP = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          is_display = 1'b0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic          dump_valid;
   logic          dump_ready = 1'b0;
   logic [DW-1:0] dump_data;
   logic [AW-1:0] dump_index;
   logic          busy;
   logic          dump_done;

   logic [DW-1:0] mem [DP];

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [AW-1:0] idx;
      logic [DW-1:0] data;
   } beat_t;

   beat_t sb_q[$];

   typedef struct {
      int rst, disp, rdy;
      int rd_en, addr, vld, idx, data, busy, done;
   } vec_t;

   vec_t tbl[18];

   mem_dump_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
      .clk         (clk),
      .rst         (rst),
      .is_display  (is_display),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .dump_valid  (dump_valid),
      .dump_ready  (dump_ready),
      .dump_data   (dump_data),
      .dump_index  (dump_index),
      .busy        (busy),
      .dump_done   (dump_done)
   );

   always #5 clk = ~clk;

   // Synchronous read memory: data appears the cycle after the strobe
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every accepted beat must match the next expected beat
   always @(negedge clk) begin
      if (!rst && dump_valid && dump_ready) begin
         if (sb_q.size() == 0) begin
            chk("beat_unexpected", 32'(dump_index), 32'hFFFF_FFFF);
         end else begin
            beat_t e;
            e = sb_q.pop_front();
            chk("beat_idx", 32'(dump_index), 32'(e.idx));
            chk("beat_data", dump_data, e.data);
         end
      end
   end

   // Expected beats for the current memory contents
   task automatic push_expected();
      for (int i = 0; i < DP; i++) begin
         beat_t b;
         b.idx  = AW'(i);
         b.data = mem[i];
`ifdef MEM_DUMP_SKIP_ZERO_EN
         if (mem[i] != '0) sb_q.push_back(b);
`else
         sb_q.push_back(b);
`endif
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      is_display = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!dump_valid && n < budget) begin
         step();
         n++;
      end
      chk("valid_reached", 32'(dump_valid), 32'd1);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!dump_done && n < budget) begin
         step();
         n++;
      end
      chk("done_reached", 32'(dump_done), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd0);
   endtask

   task automatic accept_one();
      dump_ready = 1'b1;
      step();
      dump_ready = 1'b0;
   endtask

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

      //          rst disp rdy  rd_en addr vld idx data  busy done
      tbl[0]  = '{1, 0, 1,  0, 0, 0, 0, 0,     0, 0};
      tbl[1]  = '{0, 0, 1,  0, 0, 0, 0, 0,     0, 0};
      tbl[2]  = '{0, 1, 1,  1, 0, 0, 0, 0,     1, 0};
      tbl[3]  = '{0, 1, 1,  0, 0, 0, 0, 0,     1, 0};
      tbl[4]  = '{0, 1, 1,  0, 0, 1, 0, 'h11,  1, 0};
      tbl[5]  = '{0, 1, 1,  1, 1, 0, 0, 'h11,  1, 0};
      tbl[6]  = '{0, 1, 1,  0, 1, 0, 0, 'h11,  1, 0};
      tbl[7]  = '{0, 1, 1,  0, 1, 1, 1, 'h22,  1, 0};
      tbl[8]  = '{0, 1, 1,  1, 2, 0, 1, 'h22,  1, 0};
      tbl[9]  = '{0, 1, 1,  0, 2, 0, 1, 'h22,  1, 0};
      tbl[10] = '{0, 1, 1,  0, 2, 1, 2, 'h33,  1, 0};
      tbl[11] = '{0, 1, 1,  1, 3, 0, 2, 'h33,  1, 0};
      tbl[12] = '{0, 1, 1,  0, 3, 0, 2, 'h33,  1, 0};
      tbl[13] = '{0, 1, 1,  0, 3, 1, 3, 'h44,  1, 0};
      tbl[14] = '{0, 1, 1,  0, 3, 0, 3, 'h44,  0, 1};
      tbl[15] = '{0, 0, 1,  0, 3, 0, 3, 'h44,  0, 1};
      tbl[16] = '{0, 1, 1,  0, 3, 0, 3, 'h44,  0, 1};
      tbl[17] = '{0, 1, 1,  0, 3, 0, 3, 'h44,  0, 1};

      // Basic stream, boundary index and level trigger, cycle by cycle
      push_expected();
      for (int i = 0; i < 18; i++) begin
         rst        = (tbl[i].rst != 0);
         is_display = (tbl[i].disp != 0);
         dump_ready = (tbl[i].rdy != 0);
         step();
         chk($sformatf("v%0d_rd_en", i), 32'(mem_rd_en), tbl[i].rd_en);
         chk($sformatf("v%0d_addr", i), 32'(mem_rd_addr), tbl[i].addr);
         chk($sformatf("v%0d_valid", i), 32'(dump_valid), tbl[i].vld);
         chk($sformatf("v%0d_index", i), 32'(dump_index), tbl[i].idx);
         chk($sformatf("v%0d_data", i), dump_data, tbl[i].data);
         chk($sformatf("v%0d_busy", i), 32'(busy), tbl[i].busy);
         chk($sformatf("v%0d_done", i), 32'(dump_done), tbl[i].done);
      end
      chk("basic_sb_empty", 32'(sb_q.size()), 32'd0);

      // Backpressure on beat 1
      dump_ready = 1'b0;
      do_reset();
      push_expected();
      is_display = 1'b1;
      wait_valid(20);
      accept_one();
      wait_valid(20);
      chk("bp_index", 32'(dump_index), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid_held", 32'(dump_valid), 32'd1);
         chk("bp_data_held", dump_data, 32'h22);
         chk("bp_index_held", 32'(dump_index), 32'd1);
         chk("bp_no_read", 32'(mem_rd_en), 32'd0);
      end
      dump_ready = 1'b1;
      step();
      chk("bp_valid_drop", 32'(dump_valid), 32'd0);
      wait_done(60);
      chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

      // Reset during HOLD of index 2 with is_display held high
      dump_ready = 1'b0;
      do_reset();
      push_expected();
      is_display = 1'b1;
      wait_valid(20);
      accept_one();
      wait_valid(20);
      accept_one();
      wait_valid(20);
      chk("rm_index2", 32'(dump_index), 32'd2);
      rst = 1'b1;
      step();
      chk("rm_valid_clr", 32'(dump_valid), 32'd0);
      chk("rm_done_clr", 32'(dump_done), 32'd0);
      chk("rm_busy_clr", 32'(busy), 32'd0);
      chk("rm_rd_en_clr", 32'(mem_rd_en), 32'd0);
      chk("rm_index_clr", 32'(dump_index), 32'd0);
      chk("rm_data_clr", dump_data, 32'd0);
      rst = 1'b0;
      dump_ready = 1'b1;
      sb_q.delete();
      push_expected();
      step();
      chk("rm_restart_rd", 32'(mem_rd_en), 32'd1);
      chk("rm_restart_addr", 32'(mem_rd_addr), 32'd0);
      wait_done(60);
      chk("rm_sb_empty", 32'(sb_q.size()), 32'd0);

      // Sparse memory with zero words
      mem[0] = 32'h0; mem[1] = 32'h5; mem[2] = 32'h0; mem[3] = 32'h0;
      dump_ready = 1'b1;
      do_reset();
      push_expected();
`ifdef MEM_DUMP_SKIP_ZERO_EN
      chk("sz_expect_one", 32'(sb_q.size()), 32'd1);
`else
      chk("sz_expect_four", 32'(sb_q.size()), 32'd4);
`endif
      is_display = 1'b1;
      wait_done(60);
      chk("sz_sb_empty", 32'(sb_q.size()), 32'd0);

      // All-zero memory
      mem[1] = 32'h0;
      do_reset();
      push_expected();
      is_display = 1'b1;
      wait_done(60);
      chk("az_sb_empty", 32'(sb_q.size()), 32'd0);
      chk("az_valid_low", 32'(dump_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
